// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter with a FIFO_DEPTH x 8 TX FIFO.
// Ports:
//   PCLK            sole clock, rising edge
//   PRESET          asynchronous active-high reset
//   enable          16x baud tick, one PCLK wide
//   LCR[7:0]        [1:0] word length 5..8, [2] two stop bits, [5:3] parity mode, [6] break
//   push_tx_fifo    write tx_data_in into the FIFO (ignored when full unless a pop frees a slot)
//   tx_data_in      character to send
//   TXD             serial line, idle high, driven from a flop
//   tx_fifo_count   FIFO occupancy; tx_fifo_empty / tx_fifo_full flags
//   tx_idle         FSM in IDLE and FIFO empty
// Build option: define UART_TX_BREAK_EN to let LCR[6] force TXD low (adds one PCLK of line delay).
module uart_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        enable,
    input  logic [7:0]                  LCR,
    input  logic                        push_tx_fifo,
    input  logic [7:0]                  tx_data_in,
    output logic                        TXD,
    output logic [$clog2(FIFO_DEPTH):0] tx_fifo_count,
    output logic                        tx_fifo_empty,
    output logic                        tx_fifo_full,
    output logic                        tx_idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [7:0]    r_shift;
    logic [5:0]    r_lcr;
    logic [3:0]    r_tick;
    logic [2:0]    r_bit;
    logic          r_par, r_line;
    logic          w_pop, w_push, w_adv, w_last, w_xor, w_par;
    logic [7:0]    w_head;

    assign tx_fifo_count = r_count;
    assign tx_fifo_empty = r_count == '0;
    assign tx_fifo_full  = r_count == FULL;
    assign tx_idle       = (r_state == IDLE) && tx_fifo_empty;

    // Pop only on the registered empty flag, so a push into an empty FIFO is not consumed in the same cycle.
    assign w_pop  = (r_state == IDLE) && !tx_fifo_empty;
    // A pop frees a slot in the same cycle, so a push while full is accepted only alongside a pop.
    assign w_push = push_tx_fifo && (!tx_fifo_full || w_pop);
    assign w_head = r_mem[r_rp];
    // Parity covers only the configured data bits of the character being loaded.
    assign w_xor  = ^(w_head & (8'hFF >> (2'd3 - LCR[1:0])));
    assign w_par  = LCR[5] ? ~LCR[4] : (LCR[4] ? w_xor : ~w_xor);
    assign w_adv  = enable && (r_tick == 4'd15);
    assign w_last = r_bit == ({1'b0, r_lcr[1:0]} + 3'd4);

    always_ff @(posedge PCLK) begin
        if (w_push) r_mem[r_wp] <= tx_data_in;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // r_line is updated on the same edge as the state, so the line level always matches the current state.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_line  <= 1'b1;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_lcr   <= '0;
            r_par   <= 1'b0;
        end else begin
            r_tick <= (r_state == IDLE) ? 4'd0 : r_tick + {3'd0, enable};
            case (r_state)
                IDLE: if (w_pop) begin
                    r_state <= START;
                    r_line  <= 1'b0;
                    r_shift <= w_head;
                    r_lcr   <= LCR[5:0];
                    r_par   <= w_par;
                    r_bit   <= '0;
                end
                START: if (w_adv) begin
                    r_state <= DATA;
                    r_line  <= r_shift[0];
                end
                DATA: if (w_adv) begin
                    if (w_last) begin
                        r_state <= r_lcr[3] ? PARITY : STOP1;
                        r_line  <= r_lcr[3] ? r_par : 1'b1;
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= r_shift >> 1;
                        r_line  <= r_shift[1];
                    end
                end
                PARITY: if (w_adv) begin
                    r_state <= STOP1;
                    r_line  <= 1'b1;
                end
                STOP1:   if (w_adv) r_state <= r_lcr[2] ? STOP2 : IDLE;
                STOP2:   if (w_adv) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_BREAK_EN
    // Break is live (not shadowed) but re-registered so TXD stays a flop output.
    logic r_txd;
    logic w_unused;
    assign w_unused = LCR[7];
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_txd <= 1'b1;
        else r_txd <= r_line & ~LCR[6];
    end
    assign TXD = r_txd;
`else
    logic w_unused;
    assign w_unused = ^LCR[7:6];
    assign TXD = r_line;
`endif
endmodule
